// File: rtl/progress_pkg.sv
// Shared types, constants and helpers for the progress bar feeder.
// Holds the state encoding plus the clamp/saturate arithmetic.
package progress_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Overlay step is max[24:7], so max must never fall below 128.
    localparam logic [24:0] MIN_MAX = 25'd128;

    localparam logic [7:0] HOLD_FRAMES_DEF  = 8'd50;
    localparam logic [7:0] PAUSE_FRAMES_DEF = 8'd150;

    // Floor a full-scale value at MIN_MAX.
    function automatic logic [24:0] clamp(input logic [24:0] x);
        return (x < MIN_MAX) ? MIN_MAX : x;
    endfunction

    // Limit a progress value to the full scale; v is one bit wider
    // so that addr+1 cannot wrap before the compare.
    function automatic logic [24:0] sat(input logic [25:0] v,
                                        input logic [24:0] m);
        return (v > {1'b0, m}) ? m : v[24:0];
    endfunction

endpackage

// File: rtl/progress_tracker_frame_timer.sv
// Frame timer: vblank rising-edge detect and 8-bit saturating
// frame counter with synchronous clear and expiry compare.
module frame_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vblank,
    input  logic       clear,
    input  logic [7:0] limit,
    output logic       expire
);

    logic       vblank_d;
    logic       tick;
    logic [7:0] count;
    logic [7:0] count_inc;

    assign tick      = vblank & ~vblank_d;
    assign count_inc = (count == 8'hFF) ? count : count + 8'd1;

    // Expire on the tick that brings the count up to the limit.
    assign expire = tick & ~clear & (count_inc >= limit);

    // Delayed vblank for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_d <= 1'b0;
        end else begin
            vblank_d <= vblank;
        end
    end

    // Count frame ticks, saturating at 255; clear wins over a tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (tick) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/progress_tracker.sv
// Progress bar feeder: tracks ioctl downloads and tape playback and
// drives registered enable/current/max/done for the overlay.
module progress_tracker
    import progress_pkg::*;
#(
    parameter logic [7:0] HOLD_FRAMES  = HOLD_FRAMES_DEF,
    parameter logic [7:0] PAUSE_FRAMES = PAUSE_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vblank,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [24:0] dl_size,
    input  logic        tape_play,
    input  logic [24:0] tape_ptr,
    input  logic [24:0] tape_len,
    output logic        enable,
    output logic [24:0] current,
    output logic [24:0] max,
    output logic        done
);

    state_t      state;
    logic        dl_active_d;
    logic        dl_rise;
    logic        dl_fall;
    logic        tape_end;
    logic [25:0] addr_next;
    logic        timer_clear;
    logic [7:0]  timer_limit;
    logic        timer_expire;

    assign dl_rise   = dl_active & ~dl_active_d;
    assign dl_fall   = ~dl_active & dl_active_d;
    assign tape_end  = (tape_ptr >= tape_len);
    assign addr_next = {1'b0, dl_addr} + 26'd1;

    assign timer_limit = (state == ST_PAUSE) ? PAUSE_FRAMES
                                             : HOLD_FRAMES;

    // Restart the frame count on every entry into HOLD or PAUSE.
    always_comb begin
        timer_clear = 1'b0;
        case (state)
            ST_LOAD: timer_clear = dl_fall;
            ST_PLAY: timer_clear = ~dl_rise & (tape_end | ~tape_play);
            default: timer_clear = 1'b0;
        endcase
    end

    frame_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .vblank  (vblank),
        .clear   (timer_clear),
        .limit   (timer_limit),
        .expire  (timer_expire)
    );

    // Main state machine with registered bar outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            dl_active_d <= 1'b0;
            enable      <= 1'b0;
            current     <= 25'd0;
            max         <= MIN_MAX;
            done        <= 1'b0;
        end else begin
            dl_active_d <= dl_active;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dl_rise) begin
                        state   <= ST_LOAD;
                        max     <= clamp(dl_size);
                        current <= 25'd0;
                        enable  <= 1'b1;
                    end else if (tape_play && tape_len != 25'd0) begin
                        state   <= ST_PLAY;
                        max     <= clamp(tape_len);
                        current <= sat({1'b0, tape_ptr}, clamp(tape_len));
                        enable  <= 1'b1;
                    end else begin
                        enable  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (dl_fall) begin
                        state   <= ST_HOLD;
                        current <= max;
                        done    <= 1'b1;
                    end else if (dl_wr) begin
                        current <= sat(addr_next, max);
                    end
                end
                ST_PLAY: begin
                    if (dl_rise) begin
                        state   <= ST_LOAD;
                        max     <= clamp(dl_size);
                        current <= 25'd0;
                    end else if (tape_end) begin
                        state   <= ST_HOLD;
                        current <= max;
                        done    <= 1'b1;
                    end else begin
                        current <= sat({1'b0, tape_ptr}, max);
                        if (!tape_play) begin
                            state <= ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (dl_rise) begin
                        state   <= ST_LOAD;
                        max     <= clamp(dl_size);
                        current <= 25'd0;
                    end else if (tape_play) begin
                        state   <= ST_PLAY;
                    end else if (timer_expire) begin
                        state   <= ST_IDLE;
                        enable  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (dl_rise) begin
                        state   <= ST_LOAD;
                        max     <= clamp(dl_size);
                        current <= 25'd0;
                    end else begin
                        current <= max;
                        if (timer_expire) begin
                            state  <= ST_IDLE;
                            enable <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_progress_tracker.sv
// Directed bench for progress_tracker: downloads, tape play/pause,
// preemption, saturation and async reset behaviour.
module tb_progress_tracker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vblank;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [24:0] dl_size;
    logic        tape_play;
    logic [24:0] tape_ptr;
    logic [24:0] tape_len;
    logic        enable;
    logic [24:0] current;
    logic [24:0] max;
    logic        done;

    int total = 0;
    int bad   = 0;

    progress_tracker dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vblank    (vblank),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_size   (dl_size),
        .tape_play (tape_play),
        .tape_ptr  (tape_ptr),
        .tape_len  (tape_len),
        .enable    (enable),
        .current   (current),
        .max       (max),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            vblank = 1'b1;
            tick();
            vblank = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        vblank    = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_size   = '0;
        tape_play = 1'b0;
        tape_ptr  = '0;
        tape_len  = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        chk("rst_enable", enable, 0);
        chk("rst_current", current, 0);
        chk("rst_max", max, 128);
        chk("rst_done", done, 0);

        // Download of 1000 bytes
        dl_size   = 25'd1000;
        dl_active = 1'b1;
        tick();
        chk("dl_enable", enable, 1);
        chk("dl_max", max, 1000);
        chk("dl_cur0", current, 0);
        for (int i = 0; i < 1000; i++) begin
            dl_wr   = 1'b1;
            dl_addr = 25'(i);
            tick();
            if (i == 0 || i == 499 || i == 999)
                chk("dl_track", current, 32'(i + 1));
        end
        dl_wr     = 1'b0;
        dl_active = 1'b0;
        tick();
        chk("dl_fin_cur", current, 1000);
        chk("dl_fin_done", done, 1);
        tick();
        chk("dl_done_pulse", done, 0);
        frames(49);
        chk("hold_49", enable, 1);
        chk("hold_cur", current, 1000);
        frames(1);
        chk("hold_50", enable, 0);

        // Small download, saturation, same-cycle write and fall
        dl_size   = 25'd40;
        dl_active = 1'b1;
        tick();
        chk("small_max", max, 128);
        dl_wr   = 1'b1;
        dl_addr = 25'd200;
        tick();
        chk("small_sat", current, 128);
        dl_addr = 25'd50;
        tick();
        chk("small_51", current, 51);
        dl_addr   = 25'd10;
        dl_active = 1'b0;
        tick();
        chk("wr_fall_cur", current, 128);
        chk("wr_fall_done", done, 1);
        dl_wr = 1'b0;

        // Tape play, pause, resume, pause timeout
        do_reset();
        tape_len  = 25'd50000;
        tape_ptr  = 25'd0;
        tape_play = 1'b1;
        tick();
        chk("tp_enable", enable, 1);
        chk("tp_max", max, 50000);
        chk("tp_cur0", current, 0);
        for (int p = 1; p <= 4; p++) begin
            tape_ptr = 25'(p * 5000);
            tick();
        end
        chk("tp_20000", current, 20000);
        tape_play = 1'b0;
        tick();
        frames(149);
        chk("pause_149_en", enable, 1);
        chk("pause_149_cur", current, 20000);
        tape_ptr  = 25'd20100;
        tape_play = 1'b1;
        tick();
        chk("resume_frozen", current, 20000);
        tick();
        chk("resume_track", current, 20100);
        tape_play = 1'b0;
        tick();
        frames(149);
        chk("pause2_149", enable, 1);
        frames(1);
        chk("pause2_150", enable, 0);

        // Tape runs to the end
        tape_play = 1'b1;
        tick();
        chk("tp2_cur", current, 20100);
        tape_ptr = 25'd50000;
        tick();
        chk("tp_end_cur", current, 50000);
        chk("tp_end_done", done, 1);
        tick();
        chk("tp_end_pulse", done, 0);

        // Download preempts tape in PLAY
        do_reset();
        tape_len  = 25'd50000;
        tape_ptr  = 25'd10000;
        tape_play = 1'b1;
        tick();
        tick();
        chk("pre_cur", current, 10000);
        dl_size   = 25'd3000;
        dl_active = 1'b1;
        tick();
        chk("pre_cur0", current, 0);
        chk("pre_max", max, 3000);
        chk("pre_en", enable, 1);
        dl_wr   = 1'b1;
        dl_addr = 25'd5;
        tick();
        chk("pre_load", current, 6);
        dl_wr = 1'b0;

        // Same-cycle dl_rise and tape_play from IDLE, then async reset
        do_reset();
        tape_len  = 25'd50000;
        tape_ptr  = 25'd30000;
        tape_play = 1'b1;
        dl_size   = 25'd700;
        dl_active = 1'b1;
        tick();
        chk("prio_max", max, 700);
        chk("prio_cur", current, 0);
        dl_wr   = 1'b1;
        dl_addr = 25'd99;
        tick();
        chk("prio_load", current, 100);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_en", enable, 0);
        chk("arst_cur", current, 0);
        chk("arst_max", max, 128);

        // Zero-size download, async reset while done is high
        do_reset();
        dl_size   = 25'd0;
        dl_active = 1'b1;
        tick();
        chk("zero_max", max, 128);
        dl_active = 1'b0;
        tick();
        chk("zero_cur", current, 128);
        chk("zero_done", done, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_done", done, 0);
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
